// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the RV32M multiply/divide unit:
//               default datapath width, funct3 op encodings, FSM state
//               encoding and the divide-by-zero quotient value.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int MULDIV_XLEN = 32;

    // funct3 encodings for the RV32M group
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    // Quotient returned by DIV/DIVU when the divisor is zero
    localparam logic [MULDIV_XLEN-1:0] DIV_BY_ZERO_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sign_fix
// Description : Combinational conditional two's-complement negation of the
//               2*XLEN product magnitude and of the quotient/remainder pair.
// Ports       : i_prod/i_neg_prod -> o_prod   (product, negated if flag set)
//               i_quot/i_neg_quot -> o_quot   (quotient, negated if flag set)
//               i_rem /i_neg_rem  -> o_rem    (remainder, negated if flag set)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN
) (
    input  logic [2*XLEN-1:0] i_prod,
    input  logic              i_neg_prod,
    input  logic [XLEN-1:0]   i_quot,
    input  logic              i_neg_quot,
    input  logic [XLEN-1:0]   i_rem,
    input  logic              i_neg_rem,
    output logic [2*XLEN-1:0] o_prod,
    output logic [XLEN-1:0]   o_quot,
    output logic [XLEN-1:0]   o_rem
);

    assign o_prod = i_neg_prod ? (-i_prod) : i_prod;
    assign o_quot = i_neg_quot ? (-i_quot) : i_quot;
    assign o_rem  = i_neg_rem  ? (-i_rem)  : i_rem;

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Multi-cycle RV32M multiply/divide unit. Radix-2 shift-add
//               multiply and restoring divide, one bit per cycle, on operand
//               magnitudes; sign correction is applied in FINISH.
//               Divide-by-zero and signed overflow skip the iteration.
// Ports       : clk, reset_n (async, active-low)
//               start/op/operand1/operand2 : request, sampled only in IDLE
//               flush  : abort an in-flight operation (no done)
//               busy   : high in CALC and FINISH
//               done   : one-cycle pulse, result valid in that cycle
//               result : final value, held afterwards
// Options     : `define MULDIV_SINGLE_CYCLE_MUL_EN to compute the four
//               multiply ops combinationally in the start cycle (done at T+1).
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              c_cnt_w    = $clog2(XLEN);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(XLEN - 1);
    localparam logic [XLEN-1:0] c_int_min  = {1'b1, {(XLEN-1){1'b0}}};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_op;
    logic [XLEN-1:0]     r_mag_b;
    logic [2*XLEN-1:0]   r_acc;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [XLEN-1:0]     r_result;

    logic                w_accept;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_div_zero;
    logic                w_div_ovf;
    logic                w_fast_mul;
    logic                w_skip_calc;

    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_acc;
    logic [XLEN:0]       w_div_shift;
    logic [XLEN:0]       w_div_diff;
    logic                w_div_ok;
    logic [2*XLEN-1:0]   w_div_acc;

    logic [2*XLEN-1:0]   w_fix_prod;
    logic [XLEN-1:0]     w_fix_quot;
    logic [XLEN-1:0]     w_fix_rem;
    logic [XLEN-1:0]     w_final;

    // ------------------------------------------------------------------
    // Operand decode in the start cycle
    // ------------------------------------------------------------------
    // operand1 is signed for MUL/MULH/MULHSU/DIV/REM, operand2 for
    // MUL/MULH/DIV/REM; the unsigned divide ops all have op[0]=1.
    assign w_a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                        (op == OP_DIV) || (op == OP_REM);
    assign w_b_signed = (op == OP_MUL) || (op == OP_MULH) ||
                        (op == OP_DIV) || (op == OP_REM);
    assign w_a_neg    = w_a_signed && operand1[XLEN-1];
    assign w_b_neg    = w_b_signed && operand2[XLEN-1];
    assign w_mag_a    = w_a_neg ? (-operand1) : operand1;
    assign w_mag_b    = w_b_neg ? (-operand2) : operand2;

    assign w_div_zero = op[2] && (operand2 == '0);
    assign w_div_ovf  = op[2] && !op[0] && (operand1 == c_int_min) && (operand2 == '1);

`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    logic [2*XLEN-1:0]   w_fast_prod;
    assign w_fast_prod = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
    assign w_fast_mul  = !op[2];
`else
    assign w_fast_mul  = 1'b0;
`endif

    assign w_skip_calc = w_div_zero || w_div_ovf || w_fast_mul;

    // ------------------------------------------------------------------
    // Iteration step
    // ------------------------------------------------------------------
    // Multiply: acc = {partial, multiplier}; add multiplicand to the upper
    // half when the multiplier LSB is set, then shift the whole thing right.
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                       {1'b0, (r_acc[0] ? r_mag_b : {XLEN{1'b0}})};
    assign w_mul_acc = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide: acc = {remainder, dividend}; shift one dividend bit into the
    // remainder, trial-subtract, and shift the quotient bit in at the bottom.
    assign w_div_shift = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_mag_b};
    assign w_div_ok    = !w_div_diff[XLEN];
    assign w_div_acc   = {(w_div_ok ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0]),
                          r_acc[XLEN-2:0], w_div_ok};

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                // flush has priority over a simultaneous start
                if (start && !flush) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_skip_calc ? FINISH : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (flush) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = FINISH;
                end
            end
            FINISH: begin
                busy        = 1'b1;
                done        = !flush;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op     <= '0;
            r_mag_b  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= op;
                r_mag_b <= w_mag_b;
                r_cnt   <= c_cnt_init;
                // Special cases preload the final {rem, quot} pair with no
                // sign correction so FINISH can use the normal output path.
                if (w_div_zero) begin
                    r_acc   <= {operand1, DIV_BY_ZERO_QUOTIENT[XLEN-1:0]};
                    r_neg_q <= 1'b0;
                    r_neg_r <= 1'b0;
                end else if (w_div_ovf) begin
                    r_acc   <= {{XLEN{1'b0}}, c_int_min};
                    r_neg_q <= 1'b0;
                    r_neg_r <= 1'b0;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
                end else if (w_fast_mul) begin
                    r_acc   <= w_fast_prod;
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= 1'b0;
`endif
                end else begin
                    r_acc   <= {{XLEN{1'b0}}, w_mag_a};
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    // remainder follows the dividend's sign
                    r_neg_r <= w_a_neg;
                end
            end else if ((r_state == CALC) && !flush) begin
                r_acc <= r_op[2] ? w_div_acc : w_mul_acc;
                r_cnt <= r_cnt - c_cnt_w'(1);
            end

            if (done) begin
                r_result <= w_final;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sign correction and result selection
    // ------------------------------------------------------------------
    muldiv_sign_fix #(
        .XLEN (XLEN)
    ) u_sign_fix (
        .i_prod     (r_acc),
        .i_neg_prod (r_neg_q),
        .i_quot     (r_acc[XLEN-1:0]),
        .i_neg_quot (r_neg_q),
        .i_rem      (r_acc[2*XLEN-1:XLEN]),
        .i_neg_rem  (r_neg_r),
        .o_prod     (w_fix_prod),
        .o_quot     (w_fix_quot),
        .o_rem      (w_fix_rem)
    );

    always_comb begin
        w_final = r_result;
        case (r_op)
            OP_MUL:                       w_final = w_fix_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_fix_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_final = w_fix_quot;
            default:                      w_final = w_fix_rem;
        endcase
    end

    // The new value is visible in the done cycle and latched as it retires,
    // so a flush in FINISH leaves the previous result in place.
    assign result = done ? w_final : r_result;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Directed self-checking bench for mul_div_unit: latency,
//               busy window, results of each op class, divide special
//               cases, flush abort and asynchronous reset mid-operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    localparam int c_mul_lat = 1;
`else
    localparam int c_mul_lat = 33;
`endif
    localparam int c_div_lat = 33;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        start    = 1'b0;
    logic        flush    = 1'b0;
    logic [2:0]  op       = 3'b000;
    logic [31:0] operand1 = '0;
    logic [31:0] operand2 = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    mul_div_unit #(
        .XLEN (32)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .operand1 (operand1),
        .operand2 (operand2),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request in the current cycle T and follow it to completion.
    // poke_at > 0 raises start again in cycle T+poke_at (must be ignored).
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_res,
                          input int poke_at);
        int          lat;
        int          busy_cnt;
        logic [31:0] res_done;
        lat      = 0;
        busy_cnt = 0;
        res_done = '0;
        op       = o;
        operand1 = a;
        operand2 = b;
        start    = 1'b1;
        step();
        // scramble the inputs: only the latched copies may matter
        start    = 1'b0;
        op       = OP_DIVU;
        operand1 = 32'd100;
        operand2 = 32'd7;
        for (int k = 1; k <= 40; k++) begin
            start = (k == poke_at);
            if (busy) busy_cnt++;
            if (done) begin
                lat      = k;
                res_done = result;
                break;
            end
            step();
        end
        start = 1'b0;
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, res_done, exp_res);
        check({tag, " busy cycles"}, busy_cnt, exp_lat);
        step();
        check({tag, " busy after"}, {31'd0, busy}, 32'd0);
        check({tag, " done after"}, {31'd0, done}, 32'd0);
        check({tag, " result held"}, result, exp_res);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_done;

        // ---------------- reset state ----------------
        #2;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        step();
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // ---------------- multiplies ----------------
        run_op("MUL 7*-3",      OP_MUL,    32'd7,        32'hFFFF_FFFD, c_mul_lat, 32'hFFFF_FFEB, 3);
        run_op("MULH 7*-3",     OP_MULH,   32'd7,        32'hFFFF_FFFD, c_mul_lat, 32'hFFFF_FFFF, 0);
        run_op("MULHU max*max", OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, c_mul_lat, 32'hFFFF_FFFE, 0);
        run_op("MULHSU -1*max", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c_mul_lat, 32'hFFFF_FFFF, 0);

        // ---------------- divides ----------------
        run_op("DIV -7/2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, c_div_lat, 32'hFFFF_FFFD, 0);
        run_op("REM -7/2",   OP_REM,  32'hFFFF_FFF9, 32'd2, c_div_lat, 32'hFFFF_FFFF, 0);
        run_op("DIVU 100/7", OP_DIVU, 32'd100,       32'd7, c_div_lat, 32'd14,        0);

        // ---------------- special cases ----------------
        run_op("DIV 5/0",    OP_DIV, 32'd5,         32'd0,         1, 32'hFFFF_FFFF, 0);
        run_op("REM 5/0",    OP_REM, 32'd5,         32'd0,         1, 32'd5,         0);
        run_op("REM ovf",    OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0,         0);
        run_op("DIV ovf",    OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0);

        // ---------------- flush at T+10 ----------------
        seen_done = 0;
        op        = OP_DIVU;
        operand1  = 32'd1000;
        operand2  = 32'd3;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (done) seen_done = 1;
            step();
        end
        if (done) seen_done = 1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush busy T+11", {31'd0, busy}, 32'd0);
        check("flush no done", seen_done, 0);
        check("flush result kept", result, 32'h8000_0000);
        run_op("DIVU after flush", OP_DIVU, 32'd100, 32'd7, c_div_lat, 32'd14, 0);

        // ---------------- async reset at T+5 ----------------
        op       = OP_DIV;
        operand1 = 32'd100;
        operand2 = 32'd7;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 5; k++) step();
        reset_n = 1'b0;
        #1;
        check("areset busy", {31'd0, busy}, 32'd0);
        check("areset done", {31'd0, done}, 32'd0);
        check("areset result", result, 32'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done) seen_done = 1;
        end
        check("areset no done", seen_done, 0);
        check("areset idle busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
